// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 time writer: top-level FSM states,
// command/character constants and a helper for sizing the wait counters.
package lcd_pkg;

   typedef enum logic [1:0] {
      PWRUP,
      INIT,
      IDLE,
      FRAME
   } lcd_state_t;

   localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
   localparam logic [7:0] CMD_CLEAR        = 8'h01;
   localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
   localparam logic [7:0] CMD_LINE1        = 8'h80;
   localparam logic [7:0] CMD_LINE2        = 8'hC0;
   localparam logic [7:0] CHAR_BLANK       = 8'h20;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/lcd_time_writer_if.sv
// HD44780 8-bit parallel write bus; master drives the LCD, slave observes it.
interface lcd_time_writer_if;
   logic [7:0] lcd_data;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_en;

   modport master (output lcd_data, output lcd_rs, output lcd_rw, output lcd_en);
   modport slave  (input  lcd_data, input  lcd_rs, input  lcd_rw, input  lcd_en);
endinterface

// File: rtl/lcd_byte_strobe.sv
// One HD44780 byte write: setup cycle, enable pulse, then an idle gap. Data/rs
// are held until the gap ends; done fires in the last gap cycle.
module lcd_byte_strobe #(
   parameter int EN_PULSE_CYCLES = 25,
   parameter int CNT_W           = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       data,
   input  logic             rs,
   input  logic [CNT_W-1:0] gap_cycles,
   output logic             idle,
   output logic             done,
   lcd_time_writer_if.master lcd
);
   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_GAP} strobe_state_t;

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(EN_PULSE_CYCLES - 1);

   strobe_state_t    state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [CNT_W-1:0] gap_reg, gap_next;
   logic [7:0]       data_reg, data_next;
   logic             rs_reg, rs_next;
   logic             en_reg, en_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         gap_reg   <= '0;
         data_reg  <= 8'h00;
         rs_reg    <= 1'b0;
         en_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         gap_reg   <= gap_next;
         data_reg  <= data_next;
         rs_reg    <= rs_next;
         en_reg    <= en_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      gap_next   = gap_reg;
      data_next  = data_reg;
      rs_next    = rs_reg;
      en_next    = en_reg;
      done       = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               data_next  = data;
               rs_next    = rs;
               gap_next   = gap_cycles;
               state_next = S_SETUP;
            end
         end
         S_SETUP: begin
            en_next    = 1'b1;
            cnt_next   = PULSE_LAST;
            state_next = S_PULSE;
         end
         S_PULSE: begin
            if (cnt_reg == '0) begin
               en_next    = 1'b0;
               // Saturate so a zero gap still yields one settle cycle, never a wrap.
               cnt_next   = (gap_reg == '0) ? '0 : gap_reg - 1'b1;
               state_next = S_GAP;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_reg == '0) begin
               done = 1'b1;
               // Back-to-back bytes skip the idle state so the next setup follows the gap.
               if (start) begin
                  data_next  = data;
                  rs_next    = rs;
                  gap_next   = gap_cycles;
                  state_next = S_SETUP;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign idle         = (state_reg == S_IDLE);
   assign lcd.lcd_data = data_reg;
   assign lcd.lcd_rs   = rs_reg;
   assign lcd.lcd_rw   = 1'b0;
   assign lcd.lcd_en   = en_reg;

endmodule

// File: rtl/lcd_time_writer.sv
// HD44780 time display writer: power-up wait, init sequence, then redraws the
// time chars per refresh. Define LCD_FRACTION_EN to also write line-2 fraction chars.
module lcd_time_writer
   import lcd_pkg::*;
#(
   parameter int EN_PULSE_CYCLES     = 25,
   parameter int CMD_WAIT_CYCLES     = 2500,
   parameter int CLEAR_WAIT_CYCLES   = 100000,
   parameter int POWERUP_WAIT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       refresh,
   input  logic [7:0] time_vec1,
   input  logic [7:0] time_vec2,
   input  logic [7:0] time_vec3,
   input  logic [7:0] time_vec4,
   input  logic [7:0] time_vec5,
   input  logic [7:0] fraction_tens,
   input  logic [7:0] fraction_ones,
   lcd_time_writer_if.master lcd,
   output logic       busy,
   output logic       frame_done
);
   localparam int MAX_WAIT = max4(EN_PULSE_CYCLES, CMD_WAIT_CYCLES,
                                  CLEAR_WAIT_CYCLES, POWERUP_WAIT_CYCLES);
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] PWRUP_LAST =
      (POWERUP_WAIT_CYCLES > 0) ? CNT_W'(POWERUP_WAIT_CYCLES - 1) : '0;
   localparam logic [3:0] INIT_LAST = 4'd3;
`ifdef LCD_FRACTION_EN
   localparam logic [3:0] FRAME_LAST = 4'd8;
`else
   localparam logic [3:0] FRAME_LAST = 4'd5;
`endif

   lcd_state_t       state_reg, state_next;
   logic [CNT_W-1:0] pwr_cnt_reg, pwr_cnt_next;
   logic [3:0]       idx_reg, idx_next, sel;
   logic             pending_reg, pending_next;
   logic             frame_done_reg, frame_done_next;
   logic             take_snapshot, last_byte;
   logic             start, strobe_idle, strobe_done;
   logic [7:0]       byte_data;
   logic             byte_rs;
   logic [CNT_W-1:0] byte_gap;
   logic [7:0]       time_in [5];
   logic [7:0]       time_snap_reg [5];

   assign time_in = '{time_vec1, time_vec2, time_vec3, time_vec4, time_vec5};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) time_snap_reg[i] <= CHAR_BLANK;
      end else if (take_snapshot) begin
         for (int i = 0; i < 5; i++) time_snap_reg[i] <= time_in[i];
      end
   end

`ifdef LCD_FRACTION_EN
   logic [7:0] tens_snap_reg, ones_snap_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tens_snap_reg <= CHAR_BLANK;
         ones_snap_reg <= CHAR_BLANK;
      end else if (take_snapshot) begin
         tens_snap_reg <= fraction_tens;
         ones_snap_reg <= fraction_ones;
      end
   end
`else
   logic unused_fraction;
   assign unused_fraction = ^{fraction_tens, fraction_ones};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= PWRUP;
         pwr_cnt_reg    <= PWRUP_LAST;
         idx_reg        <= '0;
         pending_reg    <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pwr_cnt_reg    <= pwr_cnt_next;
         idx_reg        <= idx_next;
         pending_reg    <= pending_next;
         frame_done_reg <= frame_done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      pwr_cnt_next    = pwr_cnt_reg;
      idx_next        = idx_reg;
      pending_next    = pending_reg | refresh;
      frame_done_next = 1'b0;
      take_snapshot   = 1'b0;
      start           = 1'b0;
      sel             = idx_reg;
      last_byte       = (state_reg == INIT) ? (idx_reg == INIT_LAST) : (idx_reg == FRAME_LAST);
      unique case (state_reg)
         PWRUP: begin
            if (pwr_cnt_reg == '0) begin
               state_next = INIT;
               idx_next   = '0;
            end else begin
               pwr_cnt_next = pwr_cnt_reg - 1'b1;
            end
         end
         INIT, FRAME: begin
            // Idle strobe means the sequence just began; afterwards each done chains the next byte.
            if (strobe_idle) begin
               start = 1'b1;
            end else if (strobe_done) begin
               if (last_byte) begin
                  state_next      = IDLE;
                  frame_done_next = (state_reg == FRAME);
               end else begin
                  start    = 1'b1;
                  sel      = idx_reg + 4'd1;
                  idx_next = sel;
               end
            end
         end
         IDLE: begin
            if (pending_reg) begin
               state_next    = FRAME;
               idx_next      = '0;
               take_snapshot = 1'b1;
               pending_next  = refresh;
            end
         end
         default: state_next = PWRUP;
      endcase
   end

   always_comb begin
      byte_data = CMD_FUNCTION_SET;
      byte_rs   = 1'b0;
      if (state_reg == INIT) begin
         case (sel)
            4'd0:    byte_data = CMD_FUNCTION_SET;
            4'd1:    byte_data = CMD_DISPLAY_ON;
            4'd2:    byte_data = CMD_CLEAR;
            default: byte_data = CMD_ENTRY_MODE;
         endcase
      end else begin
         case (sel)
            4'd0: byte_data = CMD_LINE1;
            4'd1: begin byte_data = time_snap_reg[0]; byte_rs = 1'b1; end
            4'd2: begin byte_data = time_snap_reg[1]; byte_rs = 1'b1; end
            4'd3: begin byte_data = time_snap_reg[2]; byte_rs = 1'b1; end
            4'd4: begin byte_data = time_snap_reg[3]; byte_rs = 1'b1; end
            4'd5: begin byte_data = time_snap_reg[4]; byte_rs = 1'b1; end
`ifdef LCD_FRACTION_EN
            4'd6: byte_data = CMD_LINE2;
            4'd7: begin byte_data = tens_snap_reg; byte_rs = 1'b1; end
            4'd8: begin byte_data = ones_snap_reg; byte_rs = 1'b1; end
`endif
            default: ;
         endcase
      end
   end

   assign byte_gap = (!byte_rs && byte_data == CMD_CLEAR) ? CNT_W'(CLEAR_WAIT_CYCLES)
                                                          : CNT_W'(CMD_WAIT_CYCLES);

   lcd_byte_strobe #(
      .EN_PULSE_CYCLES (EN_PULSE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_strobe (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .data       (byte_data),
      .rs         (byte_rs),
      .gap_cycles (byte_gap),
      .idle       (strobe_idle),
      .done       (strobe_done),
      .lcd        (lcd)
   );

   assign busy       = (state_reg != IDLE);
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_lcd_time_writer.sv
// Self-checking bench for lcd_time_writer: an LCD-side monitor records each
// byte write; expectations come from a byte-list model of init and frames.
module tb_lcd_time_writer;
   localparam int EN  = 2;
   localparam int CMD = 4;
   localparam int CLR = 8;
   localparam int PWR = 10;
`ifdef LCD_FRACTION_EN
   localparam int FRAME_N = 9;
`else
   localparam int FRAME_N = 6;
`endif

   logic       clk;
   logic       rst_n;
   logic       refresh;
   logic [7:0] tv [5];
   logic [7:0] ft, fo;
   logic       busy, frame_done;

   lcd_time_writer_if lcd_bus ();

   lcd_time_writer #(
      .EN_PULSE_CYCLES     (EN),
      .CMD_WAIT_CYCLES     (CMD),
      .CLEAR_WAIT_CYCLES   (CLR),
      .POWERUP_WAIT_CYCLES (PWR)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .refresh       (refresh),
      .time_vec1     (tv[0]),
      .time_vec2     (tv[1]),
      .time_vec3     (tv[2]),
      .time_vec4     (tv[3]),
      .time_vec5     (tv[4]),
      .fraction_tens (ft),
      .fraction_ones (fo),
      .lcd           (lcd_bus),
      .busy          (busy),
      .frame_done    (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] data;
      logic       rs;
      int         width;
      int         low_before;
   } byte_rec_t;

   byte_rec_t   seen [$];
   byte_rec_t   cur;
   logic [8:0]  exp_q [$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          low_run = 0, hi_run = 0, unstable = 0;
   int          fd_count = 0, fd_last_low = 0, busy_fall_low = 0;
   logic        prev_en = 1'b0, prev_busy = 1'b1;
   logic [8:0]  prev_bus = '0;

   // LCD-side observer, sampled on the falling edge away from DUT updates.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            low_run = 0; hi_run = 0; prev_en = 1'b0; prev_busy = 1'b1;
         end else begin
            if (lcd_bus.lcd_en) begin
               if (!prev_en) begin
                  cur.data       = lcd_bus.lcd_data;
                  cur.rs         = lcd_bus.lcd_rs;
                  cur.low_before = low_run;
                  hi_run         = 0;
                  if ({lcd_bus.lcd_rs, lcd_bus.lcd_data} !== prev_bus) unstable++;
               end else if ({lcd_bus.lcd_rs, lcd_bus.lcd_data} !== {cur.rs, cur.data}) begin
                  unstable++;
               end
               hi_run++;
               low_run = 0;
            end else begin
               if (prev_en) begin
                  cur.width = hi_run;
                  seen.push_back(cur);
               end
               low_run++;
            end
            if (frame_done) begin
               fd_count++;
               fd_last_low = low_run;
            end
            if (prev_busy && !busy) busy_fall_low = low_run;
            prev_en   = lcd_bus.lcd_en;
            prev_busy = busy;
            prev_bus  = {lcd_bus.lcd_rs, lcd_bus.lcd_data};
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int gap_of(input logic [8:0] b);
      return (b == 9'h001) ? CLR : CMD;
   endfunction

   task automatic push_init();
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h001);
      exp_q.push_back(9'h006);
   endtask

   task automatic push_frame();
      exp_q.push_back(9'h080);
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, tv[i]});
`ifdef LCD_FRACTION_EN
      exp_q.push_back(9'h0C0);
      exp_q.push_back({1'b1, ft});
      exp_q.push_back({1'b1, fo});
`endif
   endtask

   task automatic randomize_chars();
      for (int i = 0; i < 5; i++) tv[i] = 8'($urandom_range(126, 32));
      ft = 8'($urandom_range(126, 32));
      fo = 8'($urandom_range(126, 32));
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      tick(1);
      refresh = 1'b0;
   endtask

   task automatic check_seq(input string tag, input int base, input int eb, input int n);
      for (int i = 0; i < n; i++) begin
         if (base + i < seen.size()) begin
            check($sformatf("%s[%0d] byte", tag, i), {23'd0, seen[base+i].rs, seen[base+i].data}, {23'd0, exp_q[eb+i]});
            check($sformatf("%s[%0d] en width", tag, i), seen[base+i].width, EN);
            if (i > 0)
               check($sformatf("%s[%0d] gap", tag, i), seen[base+i].low_before, gap_of(exp_q[eb+i-1]) + 1);
         end
      end
      $display("sequence %s: %0d bytes from index %0d", tag, n, base);
   endtask

   task automatic wait_seen(input int n, input int budget, input string tag);
      int k = 0;
      while (seen.size() < n && k < budget) begin tick(1); k++; end
      check(tag, 32'(seen.size() >= n), 1);
   endtask

   task automatic wait_fd(input int target, input int budget, input string tag);
      int k = 0;
      while (fd_count < target && k < budget) begin tick(1); k++; end
      check(tag, 32'(fd_count >= target), 1);
   endtask

   task automatic wait_busy_low(input int budget, input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin tick(1); k++; end
      check(tag, busy, 0);
   endtask

   task automatic run_frame(input string tag);
      int b0, e0, f0;
      b0 = seen.size(); e0 = exp_q.size(); f0 = fd_count;
      push_frame();
      pulse_refresh();
      wait_fd(f0 + 1, 400, {tag, " frame_done seen"});
      tick(20);
      check({tag, " byte count"}, seen.size(), b0 + FRAME_N);
      check_seq(tag, b0, e0, FRAME_N);
      check({tag, " one frame_done"}, fd_count, f0 + 1);
      check({tag, " frame_done after gap"}, 32'(fd_last_low >= CMD + 1), 1);
      check({tag, " idle after"}, busy, 0);
   endtask

   task automatic restart_init(input string tag);
      int f0;
      tick(2);
      seen.delete(); exp_q.delete();
      f0 = fd_count;
      rst_n = 1'b1;
      wait_busy_low(300, {tag, " busy falls"});
      tick(20);
      push_init();
      check({tag, " byte count"}, seen.size(), 4);
      if (seen.size() > 0) check({tag, " power-up lead-in"}, 32'(seen[0].low_before >= PWR), 1);
      check_seq(tag, 0, 0, 4);
      check({tag, " busy held through gap"}, 32'(busy_fall_low >= CMD + 1), 1);
      check({tag, " no frame_done"}, fd_count, f0);
   endtask

   initial begin
      int b0, e0, f0;
      rst_n = 1'b0; refresh = 1'b0;
      for (int i = 0; i < 5; i++) tv[i] = 8'h20;
      ft = 8'h20; fo = 8'h20;
      tick(3);
      check("reset lcd_data", lcd_bus.lcd_data, 8'h00);
      check("reset lcd_rs", lcd_bus.lcd_rs, 0);
      check("reset lcd_rw", lcd_bus.lcd_rw, 0);
      check("reset lcd_en", lcd_bus.lcd_en, 0);
      check("reset busy", busy, 1);
      check("reset frame_done", frame_done, 0);

      // Power-up and init sequence.
      restart_init("init");
      check("lcd_rw stays low", lcd_bus.lcd_rw, 0);

      // Directed frame "03:45" / "12".
      tv[0] = "0"; tv[1] = "3"; tv[2] = ":"; tv[3] = "4"; tv[4] = "5";
      ft = "1"; fo = "2";
      run_frame("frame 03:45");

      for (int r = 0; r < 4; r++) begin
         randomize_chars();
         run_frame($sformatf("random frame %0d", r));
      end

      // Refreshes during a frame coalesce; mid-frame input changes land in the next frame.
      randomize_chars();
      b0 = seen.size(); e0 = exp_q.size(); f0 = fd_count;
      push_frame();
      pulse_refresh();
      wait_seen(b0 + 2, 200, "coalesce first bytes");
      randomize_chars();
      push_frame();
      for (int k = 0; k < 3; k++) begin
         pulse_refresh();
         tick(5);
      end
      wait_fd(f0 + 2, 800, "coalesce two frame_dones");
      tick(30);
      check("coalesce byte count", seen.size(), b0 + 2 * FRAME_N);
      check_seq("coalesce frame A", b0, e0, FRAME_N);
      check_seq("coalesce frame B", b0 + FRAME_N, e0 + FRAME_N, FRAME_N);
      check("coalesce frame_done count", fd_count, f0 + 2);

      // Refresh during INIT is served once INIT completes.
      rst_n = 1'b0;
      tick(2);
      seen.delete(); exp_q.delete();
      f0 = fd_count;
      randomize_chars();
      rst_n = 1'b1;
      wait_seen(1, 100, "init refresh first byte");
      pulse_refresh();
      push_init();
      push_frame();
      wait_fd(f0 + 1, 600, "init refresh frame_done");
      tick(20);
      check("init refresh byte count", seen.size(), 4 + FRAME_N);
      check_seq("init refresh init", 0, 0, 4);
      check_seq("init refresh frame", 4, 4, FRAME_N);
      check("init refresh frame_done count", fd_count, f0 + 1);

      // Reset asserted while lcd_en is high.
      randomize_chars();
      pulse_refresh();
      begin
         int k = 0;
         while (lcd_bus.lcd_en !== 1'b1 && k < 100) begin tick(1); k++; end
         check("mid-reset en high found", lcd_bus.lcd_en, 1);
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid-reset lcd_en", lcd_bus.lcd_en, 0);
      check("mid-reset lcd_data", lcd_bus.lcd_data, 8'h00);
      check("mid-reset lcd_rs", lcd_bus.lcd_rs, 0);
      check("mid-reset lcd_rw", lcd_bus.lcd_rw, 0);
      check("mid-reset busy", busy, 1);
      check("mid-reset frame_done", frame_done, 0);
      restart_init("reinit");

      check("data stable during strobes", unstable, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
